// File: rtl/decode_stage_if.sv
// decode_stage_if: Fetch, Writeback and Execute-side signals of the decode stage
interface decode_stage_if #(
    parameter int CNTRL_REG_SIZE = 8
);
    logic [0:31]               insn_in;
    logic [31:0]               pc_in;
    logic                      insn_valid;
    logic                      insn_ready;
    logic                      flush;
    logic                      stall;
    logic                      wb_we;
    logic [4:0]                wb_addr;
    logic [31:0]               wb_data;
    logic [31:0]               pc;
    logic [31:0]               rs;
    logic [31:0]               rt;
    logic [0:31]               insn;
    logic [0:CNTRL_REG_SIZE-1] control;
    logic                      dec_valid;

    modport master (
        output insn_in, pc_in, insn_valid, flush, stall, wb_we, wb_addr, wb_data,
        input  insn_ready, pc, rs, rt, insn, control, dec_valid
    );

    modport slave (
        input  insn_in, pc_in, insn_valid, flush, stall, wb_we, wb_addr, wb_data,
        output insn_ready, pc, rs, rt, insn, control, dec_valid
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: register file, control decode, load-use bubbles and flush/stall handling
module decode_stage #(
    parameter int         CNTRL_REG_SIZE = 8,
    parameter logic [5:0] LOAD_OPCODE    = 6'b100011
) (
    input logic           clock,
    input logic           reset,
    decode_stage_if.slave bus
);
    localparam int ALUINB = 0;
    localparam int ALUOP  = 1;
    localparam int BR     = 2;
    localparam int JP     = 3;
    localparam int JR     = 4;
    localparam int MEMRD  = 5;
    localparam int MEMWR  = 6;
    localparam int RWE    = 7;

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] BUBBLE = 1'b1;

    logic [31:0]               gpr [32];
    logic [0:0]                state;
    logic [5:0]                op;
    logic [5:0]                fn;
    logic [4:0]                rs_a;
    logic [4:0]                rt_a;
    logic [4:0]                ld_rt;
    logic [31:0]               rs_rd;
    logic [31:0]               rt_rd;
    logic [0:CNTRL_REG_SIZE-1] dec_ctrl;
    logic                      hazard;
    logic                      accept;

    assign op    = bus.insn_in[0:5];
    assign fn    = bus.insn_in[26:31];
    assign rs_a  = bus.insn_in[6:10];
    assign rt_a  = bus.insn_in[11:15];
    assign ld_rt = bus.insn[11:15];

    // $0 is hardwired zero; a same-cycle writeback is forwarded to the read
    assign rs_rd = (rs_a == 5'd0) ? '0 : (bus.wb_we && bus.wb_addr == rs_a) ? bus.wb_data : gpr[rs_a];
    assign rt_rd = (rt_a == 5'd0) ? '0 : (bus.wb_we && bus.wb_addr == rt_a) ? bus.wb_data : gpr[rt_a];

    // a load sitting on the outputs blocks any incoming insn that sources its destination
    assign hazard = (state == RUN) && bus.dec_valid && bus.control[MEMRD] && bus.insn_valid &&
                    (ld_rt != 5'd0) && (ld_rt == rs_a || ld_rt == rt_a);
    assign bus.insn_ready = !bus.stall && !hazard && !bus.flush;
    assign accept         = bus.insn_valid && bus.insn_ready;

    // opcode/func to control bits; unknown opcodes decode to all-zero (NOP)
    always_comb begin
        dec_ctrl = '0;
        case (op)
            6'b000000: begin
                dec_ctrl[JP]  = (fn == 6'b001000) || (fn == 6'b001001);
                dec_ctrl[JR]  = (fn == 6'b001000) || (fn == 6'b001001);
                dec_ctrl[RWE] = (fn != 6'b001000);
            end
            6'b001001, 6'b001010, 6'b001011, 6'b001101, 6'b001110: begin
                dec_ctrl[ALUINB] = 1'b1;
                dec_ctrl[RWE]    = 1'b1;
            end
            LOAD_OPCODE: begin
                dec_ctrl[ALUINB] = 1'b1;
                dec_ctrl[MEMRD]  = 1'b1;
                dec_ctrl[RWE]    = 1'b1;
            end
            6'b101011: begin
                dec_ctrl[ALUINB] = 1'b1;
                dec_ctrl[MEMWR]  = 1'b1;
            end
            6'b000100, 6'b000101, 6'b000001, 6'b000111, 6'b000110: begin
                dec_ctrl[ALUOP] = 1'b1;
                dec_ctrl[BR]    = 1'b1;
            end
            6'b000010: dec_ctrl[JP] = 1'b1;
            6'b000011: begin
                dec_ctrl[JP]  = 1'b1;
                dec_ctrl[RWE] = 1'b1;
            end
            default: dec_ctrl = '0;
        endcase
    end

    // register file write port; reset wins over a pending writeback
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
        end else if (bus.wb_we && bus.wb_addr != 5'd0) begin
            gpr[bus.wb_addr] <= bus.wb_data;
        end
    end

    // RUN/BUBBLE tracking: a hazard spends exactly one non-stalled cycle in BUBBLE
    always_ff @(posedge clock) begin
        if (reset || bus.flush) state <= RUN;
        else if (!bus.stall) state <= hazard ? BUBBLE : RUN;
    end

    // output bundle: held on stall, bubble whenever nothing is accepted
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.pc        <= '0;
            bus.rs        <= '0;
            bus.rt        <= '0;
            bus.insn      <= '0;
            bus.control   <= '0;
            bus.dec_valid <= 1'b0;
        end else if (bus.flush || !bus.stall) begin
            bus.pc        <= bus.pc_in;
            bus.rs        <= rs_rd;
            bus.rt        <= rt_rd;
            bus.insn      <= accept ? bus.insn_in : '0;
            bus.control   <= accept ? dec_ctrl : '0;
            bus.dec_valid <= accept;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed spot checks plus randomized traffic against a behavioural model
module tb_decode_stage;
    localparam logic [7:0] C_ALUINB = 8'h80;
    localparam logic [7:0] C_ALUOP  = 8'h40;
    localparam logic [7:0] C_BR     = 8'h20;
    localparam logic [7:0] C_JP     = 8'h10;
    localparam logic [7:0] C_JR     = 8'h08;
    localparam logic [7:0] C_MEMRD  = 8'h04;
    localparam logic [7:0] C_MEMWR  = 8'h02;
    localparam logic [7:0] C_RWE    = 8'h01;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    decode_stage_if bus ();
    decode_stage dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    logic [7:0]  dut_ctrl;
    logic [31:0] dut_insn;
    logic [31:0] in_w;
    assign dut_ctrl = bus.control;
    assign dut_insn = bus.insn;
    assign in_w     = bus.insn_in;

    // model state: what Execute should be seeing, plus the architectural registers
    logic        started = 1'b0;
    logic        m_valid;
    logic [31:0] m_insn;
    logic [7:0]  m_ctrl;
    logic [31:0] m_pc;
    logic [31:0] m_rs;
    logic [31:0] m_rt;
    logic [31:0] m_gpr [32];

    logic [5:0] op_tab [20] = '{6'd0, 6'd0, 6'd0, 6'd9, 6'd10, 6'd11, 6'd13, 6'd14, 6'd35, 6'd35,
                                6'd35, 6'd43, 6'd4, 6'd5, 6'd1, 6'd7, 6'd6, 6'd2, 6'd3, 6'd63};
    logic [5:0] fn_tab [6]  = '{6'd8, 6'd9, 6'd33, 6'd32, 6'd37, 6'd42};

    function automatic logic [7:0] ctrl_of(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'd0) return (fn == 6'd8) ? (C_JP | C_JR) : (fn == 6'd9) ? (C_JP | C_JR | C_RWE) : C_RWE;
        if (op inside {6'd9, 6'd10, 6'd11, 6'd13, 6'd14}) return C_ALUINB | C_RWE;
        if (op == 6'd35) return C_ALUINB | C_MEMRD | C_RWE;
        if (op == 6'd43) return C_ALUINB | C_MEMWR;
        if (op inside {6'd1, 6'd4, 6'd5, 6'd6, 6'd7}) return C_ALUOP | C_BR;
        if (op == 6'd2) return C_JP;
        if (op == 6'd3) return C_JP | C_RWE;
        return 8'h00;
    endfunction

    function automatic logic m_ready();
        logic [4:0] lrt;
        logic       blocked;
        lrt     = m_insn[20:16];
        blocked = m_valid && (m_ctrl & C_MEMRD) != 8'h00 && bus.insn_valid && lrt != 5'd0 &&
                  (lrt == in_w[25:21] || lrt == in_w[20:16]);
        return !bus.stall && !bus.flush && !blocked;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
        return m_gpr[a];
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [5:0] fn);
        return {6'd0, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [5:0] op;
        op = op_tab[$urandom_range(0, 19)];
        if (op == 6'd0)
            return rtype(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), fn_tab[$urandom_range(0, 5)]);
        return itype(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.insn_valid = 1'b0;
        bus.insn_in    = '0;
        bus.pc_in      = '0;
        bus.flush      = 1'b0;
        bus.stall      = 1'b0;
        bus.wb_we      = 1'b0;
        bus.wb_addr    = '0;
        bus.wb_data    = '0;
    endtask

    task automatic put(input logic [31:0] w, input logic [31:0] p);
        bus.insn_valid = 1'b1;
        bus.insn_in    = w;
        bus.pc_in      = p;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_we   = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    // model advance on each edge, from the rules alone
    always @(posedge clock) begin
        if (reset) begin
            started <= 1'b1;
            m_valid <= 1'b0;
            m_insn  <= '0;
            m_ctrl  <= '0;
            m_pc    <= '0;
            m_rs    <= '0;
            m_rt    <= '0;
            for (int i = 0; i < 32; i++) m_gpr[i] <= '0;
        end else begin
            if (bus.flush || !bus.stall) begin
                m_valid <= bus.insn_valid && m_ready();
                m_insn  <= (bus.insn_valid && m_ready()) ? in_w : 32'd0;
                m_ctrl  <= (bus.insn_valid && m_ready()) ? ctrl_of(in_w) : 8'd0;
                m_pc    <= bus.pc_in;
                m_rs    <= m_read(in_w[25:21]);
                m_rt    <= m_read(in_w[20:16]);
            end
            if (bus.wb_we && bus.wb_addr != 5'd0) m_gpr[bus.wb_addr] <= bus.wb_data;
        end
    end

    // every-cycle comparison of DUT against model, mid-cycle
    always @(negedge clock) begin
        #2;
        if (started) begin
            chk("insn_ready", 32'(bus.insn_ready), 32'(m_ready()));
            chk("dec_valid", 32'(bus.dec_valid), 32'(m_valid));
            chk("insn", dut_insn, m_insn);
            chk("control", 32'(dut_ctrl), 32'(m_ctrl));
            if (m_valid) begin
                chk("pc", bus.pc, m_pc);
                chk("rs", bus.rs, m_rs);
                chk("rt", bus.rt, m_rt);
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #3;
        chk("rst_ready", 32'(bus.insn_ready), 32'd1);
        chk("rst_valid", 32'(bus.dec_valid), 32'd0);
        chk("rst_pc", bus.pc, 32'd0);
        chk("rst_ctrl", 32'(dut_ctrl), 32'd0);

        @(negedge clock); wb(5'd5, 32'hDEADBEEF);
        @(negedge clock); idle(); put(rtype(5'd5, 5'd0, 5'd3, 6'd33), 32'h100);
        @(negedge clock); idle(); #3;
        chk("t1_rs", bus.rs, 32'hDEADBEEF);
        chk("t1_rt", bus.rt, 32'd0);
        chk("t1_ctrl", 32'(dut_ctrl), 32'(C_RWE));
        chk("t1_valid", 32'(bus.dec_valid), 32'd1);

        @(negedge clock); wb(5'd0, 32'h1234); put(rtype(5'd0, 5'd0, 5'd1, 6'd33), 32'h104);
        @(negedge clock); idle(); #3;
        chk("t2_rs", bus.rs, 32'd0);
        chk("t2_rt", bus.rt, 32'd0);

        @(negedge clock); wb(5'd7, 32'hA5A5A5A5); put(rtype(5'd7, 5'd7, 5'd1, 6'd37), 32'h108);
        @(negedge clock); idle(); #3;
        chk("t3_rs", bus.rs, 32'hA5A5A5A5);
        chk("t3_rt", bus.rt, 32'hA5A5A5A5);

        @(negedge clock); put(itype(6'd35, 5'd2, 5'd4, 16'd0), 32'h10C);
        @(negedge clock); put(rtype(5'd4, 5'd1, 5'd6, 6'd32), 32'h110); #3;
        chk("t4_lw_ctrl", 32'(dut_ctrl), 32'(C_ALUINB | C_MEMRD | C_RWE));
        chk("t4_ready_lo", 32'(bus.insn_ready), 32'd0);
        @(negedge clock); #3;
        chk("t4_bubble", 32'(bus.dec_valid), 32'd0);
        chk("t4_ready_hi", 32'(bus.insn_ready), 32'd1);
        @(negedge clock); idle(); #3;
        chk("t4_add", dut_insn, rtype(5'd4, 5'd1, 5'd6, 6'd32));
        chk("t4_add_ctrl", 32'(dut_ctrl), 32'(C_RWE));

        @(negedge clock); put(itype(6'd4, 5'd1, 5'd2, 16'd5), 32'h200);
        @(negedge clock); put(itype(6'd13, 5'd3, 5'd3, 16'd7), 32'h204); bus.flush = 1'b1; #3;
        chk("t5_beq_ctrl", 32'(dut_ctrl), 32'(C_ALUOP | C_BR));
        chk("t5_ready", 32'(bus.insn_ready), 32'd0);
        @(negedge clock); idle(); #3;
        chk("t5_flush_valid", 32'(bus.dec_valid), 32'd0);
        chk("t5_flush_insn", dut_insn, 32'd0);

        @(negedge clock); put({6'd3, 26'h40}, 32'h300);
        @(negedge clock); put(itype(6'd9, 5'd1, 5'd2, 16'd5), 32'h304); bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clock);
            #3;
            chk("t6_hold_ctrl", 32'(dut_ctrl), 32'(C_JP | C_RWE));
            chk("t6_hold_insn", dut_insn, {6'd3, 26'h40});
            chk("t6_ready", 32'(bus.insn_ready), 32'd0);
        end
        @(negedge clock); bus.stall = 1'b0; #3;
        chk("t6_release", 32'(bus.insn_ready), 32'd1);
        @(negedge clock); idle(); #3;
        chk("t6_next", dut_insn, itype(6'd9, 5'd1, 5'd2, 16'd5));
        chk("t6_next_ctrl", 32'(dut_ctrl), 32'(C_ALUINB | C_RWE));

        @(negedge clock); wb(5'd9, 32'h55);
        @(negedge clock); idle(); reset = 1'b1; wb(5'd9, 32'h77);
        @(negedge clock); idle(); reset = 1'b0; put(rtype(5'd9, 5'd9, 5'd1, 6'd33), 32'h400);
        @(negedge clock); idle(); #3;
        chk("rst_wb_rs", bus.rs, 32'd0);
        chk("rst_wb_rt", bus.rt, 32'd0);

        for (int n = 0; n < 4000; n++) begin
            @(negedge clock);
            reset          = ($urandom_range(0, 199) == 0);
            bus.insn_valid = ($urandom_range(0, 3) != 0);
            bus.insn_in    = rand_insn();
            bus.pc_in      = $urandom;
            bus.flush      = ($urandom_range(0, 19) == 0);
            bus.stall      = ($urandom_range(0, 9) == 0);
            bus.wb_we      = ($urandom_range(0, 1) == 1);
            bus.wb_addr    = 5'($urandom_range(0, 7));
            bus.wb_data    = $urandom;
        end
        @(negedge clock); idle(); reset = 1'b0;
        @(negedge clock); #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
